rtc_bus_ctrl: RTL and testbench
===============================

RTC_BUS_CTRL -- requirements
Module: rtc_bus_ctrl

Interface
REQ-001 SHALL have parameter T_PHASE, default 4: clock cycles per bus phase; legal range 2..255.
REQ-002 SHALL have port CLK  input  1  system clock; all state changes occur on its rising edge.
REQ-003 SHALL have port RST  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port START  input  1  request one RTC bus transaction; level sampled on each CLK edge.
REQ-005 SHALL have port RW  input  1  transaction type (1 = read, 0 = write); sampled only when START is accepted.
REQ-006 SHALL have port BUSY  output  1  transaction in progress.
REQ-007 SHALL have port DONE  output  1  one-cycle pulse marking transaction completion.
REQ-008 SHALL have port BEnv_Adress  output  1  flag to the multiplexer: drive the address onto the shared bus.
REQ-009 SHALL have port BEnv_Data  output  1  flag to the multiplexer: drive write data onto the shared bus.
REQ-010 SHALL have port BRes_Data  output  1  flag to the multiplexer: capture read data from the bus.
REQ-011 SHALL have ports CS_n, AD_n, RD_n, WR_n  output  1 each  active-low RTC chip-select, address/data select, read strobe and write strobe.

Function
REQ-012 SHALL implement states IDLE, A_SET, A_STB, A_HLD, D_SET, D_STB, D_HLD and FIN.
REQ-013 SHALL hold each of A_SET through D_HLD for exactly T_PHASE cycles, counted by a phase counter reloaded on every state entry; FIN SHALL last exactly 1 cycle.
REQ-014 SHALL accept START only in IDLE: START=1 in IDLE at edge N latches RW and enters A_SET at edge N.
REQ-015 SHALL advance states in the fixed sequence A_SET -> A_STB -> A_HLD -> D_SET -> D_STB -> D_HLD -> FIN -> IDLE.
REQ-016 SHALL ignore START in every state other than IDLE, with no queuing.
REQ-017 SHALL assert CS_n low in A_SET through D_HLD and high in IDLE and FIN.
REQ-018 SHALL assert AD_n low in A_SET, A_STB and A_HLD, and high in all other states.
REQ-019 SHALL assert WR_n low in A_STB, and also in D_STB when the latched RW=0; high otherwise.
REQ-020 SHALL assert RD_n low only in D_STB when the latched RW=1.
REQ-021 SHALL assert BEnv_Adress high in A_SET, A_STB and A_HLD.
REQ-022 SHALL assert BEnv_Data high in D_SET, D_STB and D_HLD when the latched RW=0.
REQ-023 SHALL never assert BEnv_Adress and BEnv_Data in the same cycle.
REQ-024 SHALL pulse BRes_Data high for exactly 1 cycle, on the last cycle of D_STB, when the latched RW=1, so that data is captured while RD_n is still low.
REQ-025 SHALL hold BUSY high in every state except IDLE.
REQ-026 SHALL hold DONE high only in FIN.
REQ-027 SHALL have latency such that, for START accepted at edge N, DONE is high during cycle N+6*T_PHASE and BUSY falls at edge N+6*T_PHASE+1.
REQ-028 SHALL accept START held continuously high again on the first IDLE cycle, giving back-to-back transactions with one IDLE cycle between them.
REQ-029 SHALL make all outputs registered or decoded from registered state only, with no combinational path from START or RW to any output.

Reset
REQ-030 SHALL, on RST, force the state to IDLE immediately and asynchronously, with phase counter = 0 and latched RW = 0.
REQ-031 SHALL hold these reset output values: CS_n=AD_n=RD_n=WR_n=1 and BUSY=DONE=BEnv_Adress=BEnv_Data=BRes_Data=0.
REQ-032 SHALL, when RST is asserted mid-transaction, release the bus immediately and emit no DONE; the first START after RST falls SHALL begin a fresh transaction.

Structure
REQ-033 SHALL take the state encoding and the T_PHASE default from shared package rtc_pkg, which the multiplexer and the general FSM also use.
REQ-034 SHALL use a single sub-module, rtc_phase_timer (loadable down-counter with a terminal-count output), which is natural to factor out; everything else is one FSM.

Verification
REQ-035 SHALL verify a write (T_PHASE=4, START=1 and RW=0 at edge 0): AD_n low in cycles 0-11, WR_n low in cycles 4-7 and 16-19, BEnv_Data high in cycles 12-23, DONE high in cycle 24 only, RD_n=1 and BRes_Data=0 throughout.
REQ-036 SHALL verify a read (T_PHASE=4, RW=1): RD_n low in cycles 16-19, BRes_Data high in cycle 19 only, BEnv_Data=0 throughout, DONE high in cycle 24.
REQ-037 SHALL verify that START pulsed at cycles 3 and 10 during a transaction has no effect: DONE is still high in cycle 24 only, and there is no second transaction.
REQ-038 SHALL verify that RST asserted at cycle 17 of a read brings all strobes and CS_n high within the same cycle with DONE never pulsing, and that START after release completes normally.
REQ-039 SHALL verify that START held high continuously gives DONE in cycles 24 and 50 and IDLE in cycles 25 and 51.
REQ-040 SHALL verify T_PHASE=2: DONE in cycle 12, and A_STB/D_STB strobes are each exactly 2 cycles wide.

Source files
------------

// File: rtl/rtc_pkg.sv
// rtc_pkg -- shared definitions for the RTC bus controller family.
//
// The bus controller, the bus multiplexer and the general FSM all take the
// controller state encoding and the default phase length from here, so that
// the multiplexer can decode the same state values the controller produces.
//
// Contents:
//   T_PHASE_DEF  default clock cycles per bus phase
//   PHASE_W      width of the phase counter (holds T_PHASE-1, T_PHASE <= 255)
//   rtc_state_t  controller state encoding
//   rtc_bus_t    bundle of all controller outputs, used by the output decode
//   BUS_IDLE     output bundle value for a released bus
//   is_timed()   true for the six states that last T_PHASE cycles
//   next_phase() successor in the fixed phase sequence
package rtc_pkg;

  localparam int unsigned T_PHASE_DEF = 4;
  localparam int unsigned PHASE_W     = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    A_SET = 3'd1,
    A_STB = 3'd2,
    A_HLD = 3'd3,
    D_SET = 3'd4,
    D_STB = 3'd5,
    D_HLD = 3'd6,
    FIN   = 3'd7
  } rtc_state_t;

  // Field order matches the order the debug/scoreboard views print in.
  typedef struct packed {
    logic cs_n;
    logic ad_n;
    logic rd_n;
    logic wr_n;
    logic benv_adress;
    logic benv_data;
    logic bres_data;
    logic busy;
    logic done;
  } rtc_bus_t;

  localparam rtc_bus_t BUS_IDLE = '{
    cs_n:        1'b1,
    ad_n:        1'b1,
    rd_n:        1'b1,
    wr_n:        1'b1,
    benv_adress: 1'b0,
    benv_data:   1'b0,
    bres_data:   1'b0,
    busy:        1'b0,
    done:        1'b0
  };

  function automatic logic is_timed(input rtc_state_t s);
    return (s != IDLE) && (s != FIN);
  endfunction

  function automatic rtc_state_t next_phase(input rtc_state_t s);
    rtc_state_t n;
    case (s)
      A_SET:   n = A_STB;
      A_STB:   n = A_HLD;
      A_HLD:   n = D_SET;
      D_SET:   n = D_STB;
      D_STB:   n = D_HLD;
      D_HLD:   n = FIN;
      default: n = IDLE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// rtc_phase_timer -- loadable down-counter with terminal-count flag.
//
// Loading N gives N+1 cycles of count until tc is seen high, so the
// controller loads T_PHASE-1 to hold a phase for T_PHASE cycles. The counter
// parks at zero when not reloaded.
//
// Ports:
//   CLK       clock, rising edge
//   RST       asynchronous active-high reset, clears the count
//   load      reload the counter from load_val on this edge
//   load_val  value to reload
//   tc        high while the count is zero (last cycle of the phase)
module rtc_phase_timer #(
  parameter int unsigned W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] count;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/rtc_bus_ctrl.sv
// rtc_bus_ctrl -- RTC parallel bus transaction controller.
//
// Runs one multiplexed address/data bus cycle per accepted START:
// address setup / strobe / hold, then data setup / strobe / hold, each
// T_PHASE cycles long, followed by a one-cycle FIN that pulses DONE.
//
// Request handshake: START is a level request and BUSY is its inverted
// ready. A request is taken on any rising edge where the controller is in
// IDLE (BUSY low) and START is high; RW is captured on that same edge. START
// seen while BUSY is high is dropped, never queued.
//
// Every output is decoded from the registered state, the latched RW and the
// registered phase counter, so nothing combinational runs from START or RW
// to an output. The current state is visible as the `state` variable.
//
// Ports:
//   CLK          clock, rising edge
//   RST          asynchronous active-high reset, releases the bus at once
//   START        transaction request
//   RW           1 = read, 0 = write; sampled when START is accepted
//   BUSY         transaction in progress (every state except IDLE)
//   DONE         one-cycle completion pulse (FIN)
//   BEnv_Adress  multiplexer: drive address onto the shared bus
//   BEnv_Data    multiplexer: drive write data onto the shared bus
//   BRes_Data    multiplexer: capture read data (last cycle of data strobe)
//   CS_n         RTC chip select, active low
//   AD_n         RTC address/data select, low during the address phases
//   RD_n         RTC read strobe, active low
//   WR_n         RTC write strobe, active low (also the address latch strobe)
module rtc_bus_ctrl
  import rtc_pkg::*;
#(
  parameter int unsigned T_PHASE = T_PHASE_DEF  // legal range 2..255
) (
  input  logic CLK,
  input  logic RST,
  input  logic START,
  input  logic RW,
  output logic BUSY,
  output logic DONE,
  output logic BEnv_Adress,
  output logic BEnv_Data,
  output logic BRes_Data,
  output logic CS_n,
  output logic AD_n,
  output logic RD_n,
  output logic WR_n
);

  localparam logic [PHASE_W-1:0] PHASE_RELOAD = PHASE_W'(T_PHASE - 1);

  rtc_state_t           state;
  rtc_state_t           next_state;
  logic                 rw_q;
  logic                 phase_load;
  logic [PHASE_W-1:0]   phase_val;
  logic                 phase_tc;
  rtc_bus_t             bus;

  // The counter is reloaded on every state change: timed states get
  // T_PHASE-1, FIN/IDLE get zero so the counter rests at zero between
  // transactions.
  rtc_phase_timer #(
    .W (PHASE_W)
  ) u_phase_timer (
    .CLK      (CLK),
    .RST      (RST),
    .load     (phase_load),
    .load_val (phase_val),
    .tc       (phase_tc)
  );

  // State register and RW latch.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      rw_q  <= 1'b0;
    end else begin
      state <= next_state;
      if (state == IDLE && START) begin
        rw_q <= RW;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (START) begin
          next_state = A_SET;
        end
      end
      FIN: begin
        next_state = IDLE;
      end
      default: begin
        if (phase_tc) begin
          next_state = next_phase(state);
        end
      end
    endcase
    phase_load = (next_state != state);
    phase_val  = is_timed(next_state) ? PHASE_RELOAD : '0;
  end

  // Output decode.
  always_comb begin
    bus = BUS_IDLE;
    case (state)
      A_SET, A_HLD: begin
        bus.cs_n        = 1'b0;
        bus.ad_n        = 1'b0;
        bus.benv_adress = 1'b1;
        bus.busy        = 1'b1;
      end
      A_STB: begin
        // WR_n low while AD_n is low latches the address in the RTC.
        bus.cs_n        = 1'b0;
        bus.ad_n        = 1'b0;
        bus.wr_n        = 1'b0;
        bus.benv_adress = 1'b1;
        bus.busy        = 1'b1;
      end
      D_SET, D_HLD: begin
        bus.cs_n      = 1'b0;
        bus.benv_data = ~rw_q;
        bus.busy      = 1'b1;
      end
      D_STB: begin
        bus.cs_n      = 1'b0;
        bus.wr_n      = rw_q;
        bus.rd_n      = ~rw_q;
        bus.benv_data = ~rw_q;
        // Capture on the final strobe cycle, while RD_n is still low.
        bus.bres_data = rw_q & phase_tc;
        bus.busy      = 1'b1;
      end
      FIN: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
      end
      default: begin
        bus = BUS_IDLE;
      end
    endcase
  end

  assign CS_n        = bus.cs_n;
  assign AD_n        = bus.ad_n;
  assign RD_n        = bus.rd_n;
  assign WR_n        = bus.wr_n;
  assign BEnv_Adress = bus.benv_adress;
  assign BEnv_Data   = bus.benv_data;
  assign BRes_Data   = bus.bres_data;
  assign BUSY        = bus.busy;
  assign DONE        = bus.done;

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// tb_rtc_bus_ctrl -- self-checking bench for rtc_bus_ctrl.
//
// Two instances share CLK/RST: dut_a with T_PHASE=4 and dut_b with
// T_PHASE=2. A reference model keeps, per instance, only "is a transaction
// running, on which edge did it start, read or write", and derives every
// output for a cycle from the offset into the transaction by arithmetic.
// A DONE scoreboard holds the expected completion cycle of every accepted
// transaction.
module tb_rtc_bus_ctrl;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  logic start_a = 1'b0, rw_a = 1'b0;
  logic start_b = 1'b0, rw_b = 1'b0;

  logic busy_a, done_a, benv_adr_a, benv_dat_a, bres_a, cs_n_a, ad_n_a, rd_n_a, wr_n_a;
  logic busy_b, done_b, benv_adr_b, benv_dat_b, bres_b, cs_n_b, ad_n_b, rd_n_b, wr_n_b;

  rtc_bus_ctrl #(.T_PHASE(4)) dut_a (
    .CLK(CLK), .RST(RST), .START(start_a), .RW(rw_a),
    .BUSY(busy_a), .DONE(done_a),
    .BEnv_Adress(benv_adr_a), .BEnv_Data(benv_dat_a), .BRes_Data(bres_a),
    .CS_n(cs_n_a), .AD_n(ad_n_a), .RD_n(rd_n_a), .WR_n(wr_n_a)
  );

  rtc_bus_ctrl #(.T_PHASE(2)) dut_b (
    .CLK(CLK), .RST(RST), .START(start_b), .RW(rw_b),
    .BUSY(busy_b), .DONE(done_b),
    .BEnv_Adress(benv_adr_b), .BEnv_Data(benv_dat_b), .BRes_Data(bres_b),
    .CS_n(cs_n_b), .AD_n(ad_n_b), .RD_n(rd_n_b), .WR_n(wr_n_b)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  // ---------------- reference model ----------------
  int  cyc = 0;               // index of the current cycle (posedges seen)
  bit  act[2];
  int  s_cyc[2];
  bit  rw_m[2];
  int  tp[2] = '{4, 2};

  logic [31:0] exp_q_a[$];    // expected DONE cycles, dut_a
  logic [31:0] exp_q_b[$];    // expected DONE cycles, dut_b

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  // Expected output vector {CS_n,AD_n,RD_n,WR_n,BEnv_Adress,BEnv_Data,BRes_Data,BUSY,DONE}.
  function automatic logic [8:0] exp_vec(input int i);
    int   off, ph;
    bit   last;
    logic cs, ad, rd, wr, ba, bd, br;
    if (!act[i]) return 9'b1111_0000_0;
    off = cyc - s_cyc[i];
    if (off == 6 * tp[i]) return 9'b1111_0001_1;
    ph   = off / tp[i];
    last = (off % tp[i]) == (tp[i] - 1);
    cs = 1'b0;
    ad = (ph < 3) ? 1'b0 : 1'b1;
    wr = !((ph == 1) || (ph == 4 && !rw_m[i]));
    rd = !(ph == 4 && rw_m[i]);
    ba = (ph < 3);
    bd = (ph >= 3) && !rw_m[i];
    br = (ph == 4) && rw_m[i] && last;
    return {cs, ad, rd, wr, ba, bd, br, 1'b1, 1'b0};
  endfunction

  // Called just after a rising edge, with the inputs that were sampled there.
  task automatic model_edge(input bit st0, input bit r0, input bit st1, input bit r1);
    bit st[2];
    bit rr[2];
    st = '{st0, st1};
    rr = '{r0, r1};
    for (int i = 0; i < 2; i++) begin
      if (RST) begin
        act[i] = 1'b0;
      end else if (act[i]) begin
        if (cyc == s_cyc[i] + 6 * tp[i] + 1) act[i] = 1'b0;
      end else if (st[i]) begin
        act[i]   = 1'b1;
        s_cyc[i] = cyc;
        rw_m[i]  = rr[i];
        if (i == 0) exp_q_a.push_back(32'(cyc + 6 * tp[i]));
        else        exp_q_b.push_back(32'(cyc + 6 * tp[i]));
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_a"}, {cs_n_a, ad_n_a, rd_n_a, wr_n_a, benv_adr_a, benv_dat_a, bres_a, busy_a, done_a}, exp_vec(0));
    check({tag, "_b"}, {cs_n_b, ad_n_b, rd_n_b, wr_n_b, benv_adr_b, benv_dat_b, bres_b, busy_b, done_b}, exp_vec(1));
    if (done_a) begin
      if (exp_q_a.size() == 0) check("done_spurious_a", 32'd1, 32'd0);
      else                     check("done_cycle_a", 32'(cyc), exp_q_a.pop_front());
    end
    if (done_b) begin
      if (exp_q_b.size() == 0) check("done_spurious_b", 32'd1, 32'd0);
      else                     check("done_cycle_b", 32'(cyc), exp_q_b.pop_front());
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called right after a falling edge: drive inputs, take the rising edge,
  // check on the next falling edge.
  task automatic tick(input bit s0, input bit r0, input bit s1, input bit r1);
    start_a = s0; rw_a = r0;
    start_b = s1; rw_b = r1;
    @(posedge CLK);
    cyc++;
    model_edge(s0, r0, s1, r1);
    @(negedge CLK);
    check_outputs("out");
  endtask

  task automatic idle_ticks(input int n);
    for (int k = 0; k < n; k++) tick(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Asserts RST mid-cycle, checks the bus is released before any edge,
  // holds reset across one rising edge, then releases it.
  task automatic pulse_reset();
    #2 RST = 1'b1;
    act[0] = 1'b0;
    act[1] = 1'b0;
    exp_q_a.delete();
    exp_q_b.delete();
    #1 check_outputs("rst_async");
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    RST = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    act = '{1'b0, 1'b0};

    // Reset values
    @(negedge CLK);
    check_outputs("reset");
    RST = 1'b0;

    // Single write
    tick(1'b1, 1'b0, 1'b1, 1'b0);
    idle_ticks(29);

    // Single read
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    idle_ticks(29);

    // START pulses at cycles 3 and 10 of a transaction are ignored
    for (int k = 0; k < 30; k++) begin
      bit s;
      s = (k == 0) || (k == 3) || (k == 10);
      tick(s, 1'b0, s, 1'b0);
    end

    // Reset at cycle 17 of a read, then a fresh read completes
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    idle_ticks(17);
    pulse_reset();
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    idle_ticks(29);

    // START held high: back-to-back transactions
    for (int k = 0; k < 52; k++) tick(1'b1, 1'b0, 1'b1, 1'b0);
    idle_ticks(30);

    // Randomized traffic with occasional resets
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 149) == 0) begin
        pulse_reset();
      end else begin
        tick($urandom_range(0, 5) == 0, 1'($urandom_range(0, 1)),
             $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
      end
    end
    idle_ticks(40);

    // Every accepted transaction must have completed
    check("done_pending_a", 32'(exp_q_a.size()), 32'd0);
    check("done_pending_b", 32'(exp_q_b.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
